matrix_dispatcher: RTL and testbench
====================================

Name: matrix_dispatcher

Overview:
- Job issuer feeding the five matrix compute units (a..e). It walks every output-cell coordinate of the result matrix in raster order and sends each cell to a free unit as a go pulse plus coordinates.
- It tracks which units are in flight by watching their rdy completion pulses. These are the same rdy pulses the result collector consumes.
- It issues at most one go per cycle, so equal-latency units complete on distinct cycles, which the single-output collector requires.

Parameters:
- maxWidthLen, 4, coordinate width in bits; maximum matrix dimension is 2^maxWidthLen.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a job; honoured only in IDLE.
- last_x  in  maxWidthLen  inclusive maximum column index; sampled on accepted start.
- last_y  in  maxWidthLen  inclusive maximum row index; sampled on accepted start.
- rdya..rdye  in  1 each  unit completion pulses, one cycle wide.
- goa..goe  out  1 each  registered one-cycle dispatch pulse to the unit.
- f_xa..f_xe  out  maxWidthLen each  column coordinate for the unit; held until that unit's next dispatch.
- f_ya..f_ye  out  maxWidthLen each  row coordinate for the unit; held the same way.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when every cell has been dispatched and completed.
- protocol_err  out  1  sticky flag: rdy seen from a unit that is not in flight.

Behaviour:
- Reset: all outputs 0, state IDLE, cx=cy=0, inflight[4:0]=0, latched last_x/last_y=0. Reset mid-job aborts immediately and discards all in-flight bookkeeping.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 → latch last_x/last_y, cx=cy=0, clear protocol_err, go to ISSUE; busy=1 from the next cycle.
  - start outside IDLE is ignored.
- ISSUE, each cycle:
  - The free unit with the lowest index is selected, priority a>b>c>d>e; free means inflight[i]=0.
  - If a unit is free, at the edge: go_i<=1, f_x_i<=cx, f_y_i<=cy, inflight[i]<=1, and the raster advances.
  - If no unit is free, nothing is issued.
  - Raster advance: if cx==last_x then cx=0, cy=cy+1; otherwise cx=cx+1.
  - The dispatch of (last_x,last_y) moves the state to DRAIN. No wrap beyond the last cell.
- Latency: an accepted start at edge N produces the first go visible after edge N+1.
- Completion: rdy_i with inflight[i]=1 clears inflight[i] at the edge. The unit is eligible from the following cycle; no same-cycle reuse.
  - Multiple rdy pulses in one cycle are all accepted.
  - rdy_i with inflight[i]=0, in any state including IDLE, sets protocol_err and is otherwise ignored.
- DRAIN: when inflight==0 after the current edge's clears, go to DONE.
- DONE: done=1 for one cycle, busy=0 at the same edge, then IDLE. A start in the DONE cycle is ignored.
- go and rdy cannot coincide for the same unit, because go requires inflight=0.
- Coordinate arithmetic is unsigned, maxWidthLen bits. Matrix size is (last_x+1)×(last_y+1); a 1×1 job is legal.

Decomposition:
- Package matrix_pkg: NUM_UNITS=5, the state enumeration (IDLE/ISSUE/DRAIN/DONE), the unit-index type, and a coordinate-width helper tied to maxWidthLen.
- One sub-module, matrix_raster_counter: holds cx/cy, with load-zero, advance, and an is_last flag.
- Free-unit priority select and the inflight register stay in the top level.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → all go/f_x/f_y/busy/done/protocol_err read 0 immediately; state IDLE.
- last_x=1, last_y=1, units return rdy 3 cycles after go:
  - goa(0,0), gob(1,0), goc(0,1), god(1,1) on consecutive cycles; goe never asserted.
  - done pulses one cycle after the last rdy; busy falls with it.
- last_x=3, last_y=3, no rdy returned:
  - goa..goe carry (0,0),(1,0),(2,0),(3,0),(0,1), then issue stalls.
  - Pulse rdyb → next go is gob (1,1) the cycle after the rdyb edge.
- last_x=0, last_y=0: single goa(0,0), state DRAIN; rdya → done after one cycle. start held during busy is ignored (no second go).
- rdyc pulsed while IDLE → protocol_err=1 and stays 1; next accepted start clears it to 0.
- 4×4 job: assert rst after 3 dispatches, then release and start a 2×1 job (last_x=1, last_y=0) → goa(0,0), gob(1,0); inflight fully cleared; done after both rdy.

Source files
------------

// File: rtl/matrix_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_pkg
// Description : Shared types and constants for the matrix job dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package matrix_pkg;

    localparam int NUM_UNITS       = 5;
    localparam int UNIT_IDX_W      = $clog2(NUM_UNITS);
    localparam int DEFAULT_COORD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [UNIT_IDX_W-1:0] unit_idx_t;

    // Largest matrix dimension addressable with a given coordinate width.
    function automatic int unsigned max_dim(input int unsigned coord_w);
        return 32'd1 << coord_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : matrix_raster_counter
// Description : Raster-order (column-fastest) cell coordinate walker.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_raster_counter
    import matrix_pkg::*;
#(
    parameter int maxWidthLen = DEFAULT_COORD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_zero,
    input  logic                   advance,
    input  logic [maxWidthLen-1:0] last_x,
    input  logic [maxWidthLen-1:0] last_y,
    output logic [maxWidthLen-1:0] cx,
    output logic [maxWidthLen-1:0] cy,
    output logic                   is_last
);

    logic [maxWidthLen-1:0] r_cx;
    logic [maxWidthLen-1:0] r_cy;

    // Column steps first; the end of a row wraps to column 0 of the next row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (load_zero) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (advance) begin
            if (r_cx == last_x) begin
                r_cx <= '0;
                r_cy <= r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

    assign cx      = r_cx;
    assign cy      = r_cy;
    assign is_last = (r_cx == last_x) && (r_cy == last_y);

endmodule
`default_nettype wire

// File: rtl/matrix_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : matrix_dispatcher
// Description : Issues every result-matrix cell to the first free of five
//               compute units, one dispatch per cycle, and tracks completion.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_dispatcher
    import matrix_pkg::*;
#(
    parameter int maxWidthLen = DEFAULT_COORD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [maxWidthLen-1:0] last_x,
    input  logic [maxWidthLen-1:0] last_y,
    input  logic                   rdya,
    input  logic                   rdyb,
    input  logic                   rdyc,
    input  logic                   rdyd,
    input  logic                   rdye,
    output logic                   goa,
    output logic                   gob,
    output logic                   goc,
    output logic                   god,
    output logic                   goe,
    output logic [maxWidthLen-1:0] f_xa,
    output logic [maxWidthLen-1:0] f_xb,
    output logic [maxWidthLen-1:0] f_xc,
    output logic [maxWidthLen-1:0] f_xd,
    output logic [maxWidthLen-1:0] f_xe,
    output logic [maxWidthLen-1:0] f_ya,
    output logic [maxWidthLen-1:0] f_yb,
    output logic [maxWidthLen-1:0] f_yc,
    output logic [maxWidthLen-1:0] f_yd,
    output logic [maxWidthLen-1:0] f_ye,
    output logic                   busy,
    output logic                   done,
    output logic                   protocol_err
);

    localparam logic [NUM_UNITS-1:0] c_ONE = NUM_UNITS'(1);

    state_t                 r_state;
    logic [NUM_UNITS-1:0]   r_inflight;
    logic [NUM_UNITS-1:0]   r_go;
    logic [maxWidthLen-1:0] r_fx [NUM_UNITS];
    logic [maxWidthLen-1:0] r_fy [NUM_UNITS];
    logic [maxWidthLen-1:0] r_last_x;
    logic [maxWidthLen-1:0] r_last_y;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_err;

    logic [NUM_UNITS-1:0]   w_rdy;
    logic [NUM_UNITS-1:0]   w_clear;
    logic [NUM_UNITS-1:0]   w_grant;
    logic [NUM_UNITS-1:0]   w_inflight_nxt;
    unit_idx_t              w_sel;
    logic                   w_any_free;
    logic                   w_issue;
    logic                   w_accept;
    logic                   w_stray;
    logic [maxWidthLen-1:0] w_cx;
    logic [maxWidthLen-1:0] w_cy;
    logic                   w_is_last;

    assign w_rdy    = {rdye, rdyd, rdyc, rdyb, rdya};
    assign w_accept = (r_state == ST_IDLE) && start;

    // Lowest-index free unit wins; the scan runs downward so it lands last.
    always_comb begin
        w_sel      = '0;
        w_any_free = 1'b0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (!r_inflight[i]) begin
                w_sel      = unit_idx_t'(i);
                w_any_free = 1'b1;
            end
        end
    end

    // Freeing uses the pre-edge inflight view, so a unit completing this
    // cycle is not re-granted until the next one.
    assign w_issue        = (r_state == ST_ISSUE) && w_any_free;
    assign w_grant        = w_issue ? (c_ONE << w_sel) : '0;
    assign w_clear        = w_rdy & r_inflight;
    assign w_stray        = |(w_rdy & ~r_inflight);
    assign w_inflight_nxt = (r_inflight & ~w_clear) | w_grant;

    matrix_raster_counter #(
        .maxWidthLen (maxWidthLen)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .load_zero (w_accept),
        .advance   (w_issue && !w_is_last),
        .last_x    (r_last_x),
        .last_y    (r_last_y),
        .cx        (w_cx),
        .cy        (w_cy),
        .is_last   (w_is_last)
    );

    // Control FSM with registered dispatch, coordinate and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_inflight <= '0;
            r_go       <= '0;
            r_last_x   <= '0;
            r_last_y   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                r_fx[i] <= '0;
                r_fy[i] <= '0;
            end
        end else begin
            r_go       <= w_grant;
            r_inflight <= w_inflight_nxt;
            r_err      <= w_stray | (r_err & ~w_accept);
            r_done     <= 1'b0;
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (w_grant[i]) begin
                    r_fx[i] <= w_cx;
                    r_fy[i] <= w_cy;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_last_x <= last_x;
                        r_last_y <= last_y;
                        r_busy   <= 1'b1;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue && w_is_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_inflight_nxt == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign goa  = r_go[0];
    assign gob  = r_go[1];
    assign goc  = r_go[2];
    assign god  = r_go[3];
    assign goe  = r_go[4];
    assign f_xa = r_fx[0];
    assign f_xb = r_fx[1];
    assign f_xc = r_fx[2];
    assign f_xd = r_fx[3];
    assign f_xe = r_fx[4];
    assign f_ya = r_fy[0];
    assign f_yb = r_fy[1];
    assign f_yc = r_fy[2];
    assign f_yd = r_fy[3];
    assign f_ye = r_fy[4];

    assign busy         = r_busy;
    assign done         = r_done;
    assign protocol_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_dispatcher
// Description : Scoreboard bench for matrix_dispatcher with a job-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_dispatcher;

    localparam int W  = 4;
    localparam int NU = 5;

    typedef struct packed {
        logic [NU-1:0]   go;
        logic [NU*W-1:0] fx;
        logic [NU*W-1:0] fy;
        logic            busy;
        logic            done;
        logic            err;
    } obs_t;

    typedef struct {
        int x;
        int y;
    } cell_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  last_x = '0;
    logic [W-1:0]  last_y = '0;
    logic [NU-1:0] rdy = '0;

    logic goa, gob, goc, god, goe, busy, done, protocol_err;
    logic [W-1:0] f_xa, f_xb, f_xc, f_xd, f_xe;
    logic [W-1:0] f_ya, f_yb, f_yc, f_yd, f_ye;

    matrix_dispatcher #(.maxWidthLen(W)) dut (
        .clk(clk), .rst(rst), .start(start), .last_x(last_x), .last_y(last_y),
        .rdya(rdy[0]), .rdyb(rdy[1]), .rdyc(rdy[2]), .rdyd(rdy[3]), .rdye(rdy[4]),
        .goa(goa), .gob(gob), .goc(goc), .god(god), .goe(goe),
        .f_xa(f_xa), .f_xb(f_xb), .f_xc(f_xc), .f_xd(f_xd), .f_xe(f_xe),
        .f_ya(f_ya), .f_yb(f_yb), .f_yc(f_yc), .f_yd(f_yd), .f_ye(f_ye),
        .busy(busy), .done(done), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    wire [NU-1:0]   go_v = {goe, god, goc, gob, goa};
    wire [NU*W-1:0] fx_v = {f_xe, f_xd, f_xc, f_xb, f_xa};
    wire [NU*W-1:0] fy_v = {f_ye, f_yd, f_yc, f_yb, f_ya};

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: job as a queue of remaining cells.
    obs_t     exp_q[$];
    cell_t    cells[$];
    int       mode;          // 0 idle, 1 job active, 2 done-pulse cycle
    bit       infl[NU];
    int       cnt[NU];       // cycles until the emulated unit answers
    logic [W-1:0] mfx[NU];
    logic [W-1:0] mfy[NU];
    bit       merr, mbusy, mdone;
    int       lat_mode;      // 0 never answer, >0 fixed, <0 random
    bit       spur_en;
    logic [NU-1:0] spur_once = '0;

    task automatic model_reset();
        mode = 0; merr = 0; mbusy = 0; mdone = 0;
        for (int i = 0; i < NU; i++) begin
            infl[i] = 0; cnt[i] = 0; mfx[i] = '0; mfy[i] = '0;
        end
        cells.delete();
        exp_q.delete();
    endtask

    // Predicts the outputs visible after the coming clock edge.
    task automatic model_step();
        int    g;
        bit    bad;
        bit    drain;
        bit    idle_all;
        cell_t c;
        obs_t  e;
        g = -1; bad = 0; drain = 0; mdone = 0;
        for (int i = 0; i < NU; i++) if (rdy[i] && !infl[i]) bad = 1;
        if (mode == 0 && start) merr = 0;
        if (bad) merr = 1;
        case (mode)
            0: if (start) begin
                for (int y = 0; y <= int'(last_y); y++)
                    for (int x = 0; x <= int'(last_x); x++) begin
                        c.x = x; c.y = y; cells.push_back(c);
                    end
                mode = 1; mbusy = 1;
            end
            1: if (cells.size() > 0) begin
                for (int i = NU - 1; i >= 0; i--) if (!infl[i]) g = i;
                if (g >= 0) begin
                    c = cells.pop_front();
                    mfx[g] = W'(c.x); mfy[g] = W'(c.y);
                end
            end else drain = 1;
            default: mode = 0;
        endcase
        for (int i = 0; i < NU; i++) if (rdy[i] && infl[i]) infl[i] = 0;
        if (g >= 0) begin
            infl[g] = 1;
            if (lat_mode > 0) cnt[g] = lat_mode;
            else if (lat_mode < 0) cnt[g] = $urandom_range(1, 8);
        end
        idle_all = 1;
        for (int i = 0; i < NU; i++) if (infl[i]) idle_all = 0;
        if (drain && idle_all) begin
            mode = 2; mdone = 1; mbusy = 0;
        end
        e.go = '0;
        if (g >= 0) e.go[g] = 1'b1;
        for (int i = 0; i < NU; i++) begin
            e.fx[i*W +: W] = mfx[i];
            e.fy[i*W +: W] = mfy[i];
        end
        e.busy = mbusy; e.done = mdone; e.err = merr;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: emulated unit answers, model prediction, edge.
    task automatic step();
        logic [NU-1:0] r;
        r = spur_once;
        spur_once = '0;
        for (int i = 0; i < NU; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) r[i] = 1'b1;
            end else if (spur_en && !infl[i] && !(mode == 0 && start)
                         && $urandom_range(0, 49) == 0) begin
                r[i] = 1'b1;
            end
        end
        rdy = r;
        model_step();
        @(posedge clk);
        #4;
        rdy = '0;
    endtask

    task automatic start_job(input int lx, input int ly);
        last_x = W'(lx);
        last_y = W'(ly);
        start  = 1'b1;
        step();
        start  = 1'b0;
        last_x = W'($urandom_range(0, 15));
        last_y = W'($urandom_range(0, 15));
    endtask

    task automatic run_until_idle(input int limit, input bit hold, input bit rnd);
        int n;
        n = 0;
        while (mode != 0) begin
            if (n >= limit) begin
                vectors++;
                miscompares++;
                $display("FAIL job-timeout: still active after %0d cycles, required idle", n);
                break;
            end
            start = hold || (rnd && mode == 1 && $urandom_range(0, 7) == 0);
            step();
            n++;
        end
        start = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        obs_t a;
        a = {go_v, fx_v, fy_v, busy, done, protocol_err};
        vectors++;
        if (a !== '0) begin
            miscompares++;
            $display("FAIL %s: outputs=%h required all zero", tag, a);
        end
    endtask

    task automatic kick_inflight();
        for (int i = 0; i < NU; i++)
            if (infl[i] && cnt[i] == 0) cnt[i] = $urandom_range(1, 6);
    endtask

    // Monitor: each cycle that has a prediction, compare the whole output set.
    obs_t mon_exp, mon_act;
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {go_v, fx_v, fy_v, busy, done, protocol_err};
            vectors++;
            if (mon_act !== mon_exp) begin
                miscompares++;
                $display("FAIL outputs t=%0t: act go=%b fx=%h fy=%h busy=%b done=%b err=%b, exp go=%b fx=%h fy=%h busy=%b done=%b err=%b",
                         $time, mon_act.go, mon_act.fx, mon_act.fy, mon_act.busy, mon_act.done, mon_act.err,
                         mon_exp.go, mon_exp.fx, mon_exp.fy, mon_exp.busy, mon_exp.done, mon_exp.err);
            end
        end
    end

    initial begin
        model_reset();
        lat_mode = 3;
        spur_en  = 0;
        #1 rst = 1'b1;
        #1 check_zero("power-on reset");
        @(posedge clk); @(posedge clk); #4;
        rst = 1'b0;
        step();

        // 2x2 job, units answer 3 cycles after go
        lat_mode = 3;
        start_job(1, 1);
        run_until_idle(200, 0, 0);
        step();

        // 4x4 job with no answers: issue stalls after five, then rdyb frees b
        lat_mode = 0;
        start_job(3, 3);
        repeat (8) step();
        cnt[1] = 1;
        step();
        step();
        lat_mode = -1;
        kick_inflight();
        run_until_idle(400, 0, 0);
        step();

        // 1x1 job with start held high throughout
        lat_mode = 2;
        start_job(0, 0);
        run_until_idle(100, 1, 0);
        step();
        step();

        // stray completion while idle, then a fresh start clears the flag
        spur_once = 5'b00100;
        step();
        step();
        step();
        lat_mode = 1;
        start_job(1, 0);
        run_until_idle(100, 0, 0);
        step();

        // reset in the middle of a 4x4 job, then a 2x1 job
        lat_mode = 0;
        start_job(3, 3);
        repeat (3) step();
        rst = 1'b1;
        #1 check_zero("mid-job reset");
        model_reset();
        @(posedge clk); @(posedge clk); #4;
        rst = 1'b0;
        check_zero("after reset release");
        step();
        lat_mode = 3;
        start_job(1, 0);
        run_until_idle(100, 0, 0);
        step();

        // randomized jobs, latencies, stray completions and ignored starts
        lat_mode = -1;
        spur_en  = 1;
        repeat (40) begin
            int lx, ly;
            lx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            ly = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            start_job(lx, ly);
            run_until_idle(4000, 0, 1);
            repeat ($urandom_range(0, 3)) step();
        end
        spur_en = 0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
